// File: rtl/uart_resp_pkg.sv
// uart_resp_pkg: FSM states, default sync marker and payload byte order for uart_response_tx
package uart_resp_pkg;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam bit PAYLOAD_LSB_FIRST = 1'b1;
  typedef enum logic [3:0] {IDLE, SYNC, OPC, LEN, FETCH, WAIT, PAYLOAD, CSUM, DONE} state_t;
endpackage

// File: rtl/resp_checksum.sv
// resp_checksum: modulo-256 byte accumulator with synchronous clear
module resp_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] sum
);
  // clear wins over add so a new frame never inherits the old sum
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= 8'h00;
    else if (clear) sum <= 8'h00;
    else if (add) sum <= sum + data;
endmodule

// File: rtl/uart_response_tx.sv
// uart_response_tx: streams SYNC, opcode, length, BRAM payload and, with RESP_CHECKSUM_EN, a checksum byte into a UART TX FIFO
module uart_response_tx
  import uart_resp_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [7:0]        opcode,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [7:0]        length,
  output logic              busy,
  output logic              send_complete,
  output logic              bram_read_enable,
  output logic [ADDR_W-1:0] bram_read_addr,
  input  logic [31:0]       bram_data_in,
  input  logic              uart_buffer_full,
  output logic [7:0]        uart_data_out,
  output logic              uart_data_write
);
`ifdef RESP_CHECKSUM_EN
  localparam state_t TAIL = CSUM;
`else
  localparam state_t TAIL = DONE;
`endif
  state_t state;
  logic [7:0] opc_q, len_q, remain, cur_byte, frame_byte;
  logic [31:0] word, word_next;
  logic [1:0] idx;
  logic [ADDR_W-1:0] addr;
  assign busy = state != IDLE;
  assign send_complete = state == DONE;
  assign bram_read_enable = state == FETCH;
  assign bram_read_addr = addr;
  assign uart_data_write = (state inside {SYNC, OPC, LEN, PAYLOAD, CSUM}) && !uart_buffer_full;
  assign cur_byte = PAYLOAD_LSB_FIRST ? word[7:0] : word[31:24];
  assign word_next = PAYLOAD_LSB_FIRST ? {8'h00, word[31:8]} : {word[23:0], 8'h00};
  assign frame_byte = state == SYNC ? SYNC_BYTE :
                      state == OPC ? opc_q :
                      state == LEN ? len_q :
                      state == PAYLOAD ? cur_byte : 8'h00;
`ifdef RESP_CHECKSUM_EN
  logic [7:0] csum;
  resp_checksum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE && enable),
    .add   (uart_data_write && (state inside {OPC, LEN, PAYLOAD})),
    .data  (uart_data_out),
    .sum   (csum)
  );
  assign uart_data_out = state == CSUM ? csum : frame_byte;
`else
  assign uart_data_out = frame_byte;
`endif
  // frame sequencer; emitting states advance only on an accepted FIFO write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      opc_q <= 8'h00;
      len_q <= 8'h00;
      remain <= 8'h00;
      addr <= '0;
      word <= 32'h0;
      idx <= 2'd0;
    end else
      case (state)
        IDLE: if (enable) begin
          state <= SYNC;
          opc_q <= opcode;
          len_q <= length;
          remain <= length;
          addr <= read_addr;
        end
        SYNC: if (uart_data_write) state <= OPC;
        OPC: if (uart_data_write) state <= LEN;
        LEN: if (uart_data_write) state <= len_q == 8'd0 ? TAIL : FETCH;
        FETCH: begin
          state <= WAIT;
          addr <= addr + 1'b1;
        end
        WAIT: begin
          state <= PAYLOAD;
          word <= bram_data_in;
          idx <= 2'd0;
        end
        PAYLOAD: if (uart_data_write) begin
          word <= word_next;
          remain <= remain - 8'd1;
          idx <= idx + 2'd1;
          state <= remain == 8'd1 ? TAIL : idx == 2'd3 ? FETCH : PAYLOAD;
        end
        CSUM: if (uart_data_write) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_response_tx.sv
// tb_uart_response_tx: scoreboard bench for uart_response_tx, checksum byte expected only with RESP_CHECKSUM_EN
module tb_uart_response_tx;
  localparam int AW = 9;
`ifdef RESP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  typedef struct {
    logic [7:0]    op;
    logic [7:0]    len;
    logic [AW-1:0] addr;
    int            stall_at;
    int            stall_len;
    bit            hold_en;
  } vec_t;
  logic clk = 0, rst_n = 0, enable = 0, uart_buffer_full = 0;
  logic [7:0] opcode = 0, length = 0;
  logic [AW-1:0] read_addr = '0;
  logic busy, send_complete, bram_read_enable, uart_data_write;
  logic [AW-1:0] bram_read_addr;
  logic [31:0] bram_data_in;
  logic [7:0] uart_data_out;
  logic [31:0] mem [0:511];
  logic [7:0] obs_q[$], exp_q[$];
  logic [AW-1:0] obs_rd[$], exp_rd[$];
  int nbytes = 0, full_wr = 0;
  int checks = 0, errors = 0;
  vec_t vecs[8];
  uart_response_tx #(.SYNC_BYTE(8'hA5), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .opcode           (opcode),
    .read_addr        (read_addr),
    .length           (length),
    .busy             (busy),
    .send_complete    (send_complete),
    .bram_read_enable (bram_read_enable),
    .bram_read_addr   (bram_read_addr),
    .bram_data_in     (bram_data_in),
    .uart_buffer_full (uart_buffer_full),
    .uart_data_out    (uart_data_out),
    .uart_data_write  (uart_data_write)
  );
  always #5 clk = ~clk;
  // BRAM model: one-cycle read latency
  always @(posedge clk) if (bram_read_enable) bram_data_in <= mem[bram_read_addr];
  // record every FIFO write and BRAM read away from the active edge
  always @(negedge clk) begin
    if (uart_data_write) begin
      obs_q.push_back(uart_data_out);
      nbytes <= nbytes + 1;
      if (uart_buffer_full) full_wr <= full_wr + 1;
    end
    if (bram_read_enable) obs_rd.push_back(bram_read_addr);
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_expected(input vec_t v);
    logic [7:0] sum, b;
    logic [31:0] w;
    logic [AW-1:0] a;
    exp_q.push_back(8'hA5);
    exp_q.push_back(v.op);
    exp_q.push_back(v.len);
    sum = 8'(v.op + v.len);
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.addr + AW'(i / 4);
      if (i % 4 == 0) exp_rd.push_back(a);
      w = mem[a];
      b = w[8*(i%4) +: 8];
      exp_q.push_back(b);
      sum += b;
    end
    if (CS == 1) exp_q.push_back(sum);
  endtask
  task automatic check_outputs_reset(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " send_complete"}, send_complete, 0);
    chk({tag, " bram_read_enable"}, bram_read_enable, 0);
    chk({tag, " uart_data_write"}, uart_data_write, 0);
    chk({tag, " uart_data_out"}, uart_data_out, 0);
    chk({tag, " bram_read_addr"}, bram_read_addr, 0);
  endtask
  task automatic compare_frame(input string tag, input int fbase);
    while (exp_q.size() > 0 && obs_q.size() > 0) chk({tag, " byte"}, obs_q.pop_front(), exp_q.pop_front());
    chk({tag, " missing bytes"}, exp_q.size(), 0);
    chk({tag, " extra bytes"}, obs_q.size(), 0);
    while (exp_rd.size() > 0 && obs_rd.size() > 0) chk({tag, " read addr"}, obs_rd.pop_front(), exp_rd.pop_front());
    chk({tag, " missing reads"}, exp_rd.size(), 0);
    chk({tag, " extra reads"}, obs_rd.size(), 0);
    chk({tag, " write while full"}, full_wr - fbase, 0);
    exp_q.delete();
    obs_q.delete();
    exp_rd.delete();
    obs_rd.delete();
  endtask
  task automatic run_frame(input vec_t v, input string tag);
    int cyc, stall_left, base, fbase, exp_cyc;
    bit done, stalled;
    fbase = full_wr;
    exp_cyc = 3 + 2 * ((int'(v.len) + 3) / 4) + int'(v.len) + CS;
    push_expected(v);
    @(posedge clk); #1;
    opcode = v.op;
    length = v.len;
    read_addr = v.addr;
    enable = 1;
    base = nbytes;
    @(posedge clk); #1;
    if (!v.hold_en) enable = 0;
    opcode = 8'($urandom);
    length = 8'($urandom);
    read_addr = AW'($urandom);
    cyc = 0;
    done = 0;
    stalled = 0;
    stall_left = 0;
    while (!done && cyc < 3000) begin
      if (v.stall_len > 0 && !stalled && nbytes - base >= v.stall_at) begin
        uart_buffer_full = 1;
        stalled = 1;
        stall_left = v.stall_len;
      end
      @(negedge clk);
      if (send_complete) done = 1;
      else begin
        chk({tag, " busy in frame"}, busy, 1);
        cyc++;
        @(posedge clk); #1;
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) uart_buffer_full = 0;
        end
      end
    end
    chk({tag, " reached done"}, done, 1);
    if (v.stall_len == 0) chk({tag, " cycles"}, cyc, exp_cyc);
    chk({tag, " busy in done"}, busy, 1);
    @(posedge clk); #1;
    enable = 0;
    uart_buffer_full = 0;
    @(negedge clk);
    chk({tag, " pulse width"}, send_complete, 0);
    chk({tag, " busy after"}, busy, 0);
    compare_frame(tag, fbase);
  endtask
  initial begin
    int fbase, nb;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[5] = 32'h44332211;
    mem[6] = 32'h00006655;
    vecs[0] = '{8'h10, 8'd0, 9'd0, 0, 0, 1'b0};
    vecs[1] = '{8'h22, 8'd6, 9'd5, 0, 0, 1'b0};
    vecs[2] = '{8'h22, 8'd6, 9'd5, 5, 10, 1'b0};
    vecs[3] = '{8'h3C, 8'd8, 9'd511, 0, 0, 1'b0};
    vecs[4] = '{8'h7F, 8'd1, 9'd100, 0, 0, 1'b1};
    vecs[5] = '{8'hFF, 8'd255, 9'd508, 0, 0, 1'b0};
    vecs[6] = '{8'h01, 8'd4, 9'd200, 0, 0, 1'b0};
    vecs[7] = '{8'h5A, 8'd7, 9'd33, 0, 3, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check_outputs_reset("reset");
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("v%0d", i));
    fbase = nbytes;
    push_expected(vecs[1]);
    @(posedge clk); #1;
    opcode = 8'h22;
    length = 8'd6;
    read_addr = 9'd5;
    enable = 1;
    @(posedge clk); #1;
    enable = 0;
    for (int k = 0; k < 100 && nbytes - fbase < 6; k++) begin
      @(posedge clk); #1;
    end
    nb = nbytes - fbase;
    chk("midrst bytes before reset", nb, 6);
    #2 rst_n = 0;
    #1;
    check_outputs_reset("midrst");
    exp_q.delete();
    exp_rd.delete();
    obs_q.delete();
    obs_rd.delete();
    @(negedge clk);
    rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst no resume bytes", obs_q.size(), 0);
    chk("midrst no resume reads", obs_rd.size(), 0);
    run_frame(vecs[1], "after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
